// File: rtl/e_m_reg.sv
// E/M pipeline register: captures execute-stage results for the memory stage,
// merging ALU/address overflow into the exception code and killing side effects of faulting instructions.
module e_m_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        E_Valid,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_Instr,
  input  logic [31:0] E_ALURes,
  input  logic [31:0] E_WriteData,
  input  logic [4:0]  E_WriteReg,
  input  logic        E_BD,
  input  logic [4:0]  E_ExcCode,
  input  logic        E_Ari_Ov,
  input  logic        E_DM_Ov,
  input  logic        E_IsLoad,
  input  logic        E_IsStore,
  output logic        M_Valid,
  output logic [31:0] M_PC,
  output logic [31:0] M_Instr,
  output logic [31:0] M_ALURes,
  output logic [31:0] M_WriteData,
  output logic [4:0]  M_WriteReg,
  output logic        M_BD,
  output logic [4:0]  M_ExcCode,
  output logic        M_IsLoad,
  output logic        M_IsStore
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  logic [4:0] w_mergedExc;
  logic       w_killCtrl;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_aluRes;
  logic [31:0] r_writeData;
  logic [4:0]  r_writeReg;
  logic        r_bd;
  logic [4:0]  r_excCode;
  logic        r_isLoad;
  logic        r_isStore;

  // An exception raised earlier in the pipe outranks anything detected in E.
  always_comb begin
    w_mergedExc = EXC_NONE;
    if (E_Valid) begin
      if (E_ExcCode != EXC_NONE)        w_mergedExc = E_ExcCode;
      else if (E_Ari_Ov)                w_mergedExc = EXC_OV;
      else if (E_DM_Ov && E_IsLoad)     w_mergedExc = EXC_ADEL;
      else if (E_DM_Ov && E_IsStore)    w_mergedExc = EXC_ADES;
    end
    w_killCtrl = !E_Valid || (w_mergedExc != EXC_NONE);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_instr     <= '0;
      r_aluRes    <= '0;
      r_writeData <= '0;
      r_writeReg  <= '0;
      r_bd        <= 1'b0;
      r_excCode   <= '0;
      r_isLoad    <= 1'b0;
      r_isStore   <= 1'b0;
    end else if (!stall) begin
      r_valid     <= E_Valid;
      r_pc        <= E_PC;
      r_instr     <= E_Instr;
      r_aluRes    <= E_ALURes;
      r_writeData <= E_WriteData;
      r_writeReg  <= w_killCtrl ? 5'd0 : E_WriteReg;
      r_bd        <= E_BD;
      r_excCode   <= w_mergedExc;
      r_isLoad    <= w_killCtrl ? 1'b0 : E_IsLoad;
      r_isStore   <= w_killCtrl ? 1'b0 : E_IsStore;
    end
  end

  assign M_Valid     = r_valid;
  assign M_PC        = r_pc;
  assign M_Instr     = r_instr;
  assign M_ALURes    = r_aluRes;
  assign M_WriteData = r_writeData;
  assign M_WriteReg  = r_writeReg;
  assign M_BD        = r_bd;
  assign M_ExcCode   = r_excCode;
  assign M_IsLoad    = r_isLoad;
  assign M_IsStore   = r_isStore;

endmodule

// File: tb/tb_e_m_reg.sv
// Self-checking bench for e_m_reg: directed scenarios plus randomized traffic
// compared against a behavioural model of the M-stage contents.
module tb_e_m_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        E_Valid = 1'b0;
  logic [31:0] E_PC = '0, E_Instr = '0, E_ALURes = '0, E_WriteData = '0;
  logic [4:0]  E_WriteReg = '0, E_ExcCode = '0;
  logic        E_BD = 1'b0, E_Ari_Ov = 1'b0, E_DM_Ov = 1'b0, E_IsLoad = 1'b0, E_IsStore = 1'b0;

  logic        M_Valid, M_BD, M_IsLoad, M_IsStore;
  logic [31:0] M_PC, M_Instr, M_ALURes, M_WriteData;
  logic [4:0]  M_WriteReg, M_ExcCode;

  typedef struct {
    logic        valid;
    logic [31:0] pc, instr, aluRes, writeData;
    logic [4:0]  writeReg, excCode;
    logic        bd, isLoad, isStore;
  } mState_t;

  mState_t model;
  int checkCount = 0;
  int failCount  = 0;

  e_m_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .E_Valid(E_Valid), .E_PC(E_PC), .E_Instr(E_Instr), .E_ALURes(E_ALURes),
    .E_WriteData(E_WriteData), .E_WriteReg(E_WriteReg), .E_BD(E_BD),
    .E_ExcCode(E_ExcCode), .E_Ari_Ov(E_Ari_Ov), .E_DM_Ov(E_DM_Ov),
    .E_IsLoad(E_IsLoad), .E_IsStore(E_IsStore),
    .M_Valid(M_Valid), .M_PC(M_PC), .M_Instr(M_Instr), .M_ALURes(M_ALURes),
    .M_WriteData(M_WriteData), .M_WriteReg(M_WriteReg), .M_BD(M_BD),
    .M_ExcCode(M_ExcCode), .M_IsLoad(M_IsLoad), .M_IsStore(M_IsStore)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Expected exception code from the pipeline rules: invalid slots carry nothing,
  // otherwise the oldest exception wins, then overflow, then address errors.
  function automatic logic [4:0] expectedExc();
    if (!E_Valid) return 5'd0;
    if (E_ExcCode != 0) return E_ExcCode;
    if (E_Ari_Ov) return 5'd12;
    if (E_DM_Ov && E_IsLoad) return 5'd4;
    if (E_DM_Ov && E_IsStore) return 5'd5;
    return 5'd0;
  endfunction

  function automatic mState_t zeroState();
    mState_t s;
    s.valid = 0; s.pc = 0; s.instr = 0; s.aluRes = 0; s.writeData = 0;
    s.writeReg = 0; s.excCode = 0; s.bd = 0; s.isLoad = 0; s.isStore = 0;
    return s;
  endfunction

  task automatic updateModel();
    logic [4:0] exc;
    logic       live;
    if (reset || flush) begin
      model = zeroState();
    end else if (!stall) begin
      exc  = expectedExc();
      live = E_Valid && (exc == 0);
      model.valid     = E_Valid;
      model.pc        = E_PC;
      model.instr     = E_Instr;
      model.aluRes    = E_ALURes;
      model.writeData = E_WriteData;
      model.bd        = E_BD;
      model.excCode   = exc;
      model.writeReg  = live ? E_WriteReg : 5'd0;
      model.isLoad    = live ? E_IsLoad : 1'b0;
      model.isStore   = live ? E_IsStore : 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("valid",     {31'd0, M_Valid},     {31'd0, model.valid});
    checkOutput("pc",        M_PC,                 model.pc);
    checkOutput("instr",     M_Instr,              model.instr);
    checkOutput("aluRes",    M_ALURes,             model.aluRes);
    checkOutput("writeData", M_WriteData,          model.writeData);
    checkOutput("writeReg",  {27'd0, M_WriteReg},  {27'd0, model.writeReg});
    checkOutput("bd",        {31'd0, M_BD},        {31'd0, model.bd});
    checkOutput("excCode",   {27'd0, M_ExcCode},   {27'd0, model.excCode});
    checkOutput("isLoad",    {31'd0, M_IsLoad},    {31'd0, model.isLoad});
    checkOutput("isStore",   {31'd0, M_IsStore},   {31'd0, model.isStore});
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic fl);
    reset = rst; stall = st; flush = fl;
    @(posedge clk);
    updateModel();
    #1;
    checkAll();
  endtask

  task automatic setE(input logic v, input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] wr,
                      input logic [4:0] exc, input logic ari, input logic dm, input logic ld, input logic sto);
    E_Valid = v; E_PC = pc; E_ALURes = alu; E_WriteReg = wr; E_ExcCode = exc;
    E_Ari_Ov = ari; E_DM_Ov = dm; E_IsLoad = ld; E_IsStore = sto;
    E_Instr = pc ^ 32'hA5A5_0000; E_WriteData = alu + 32'd7; E_BD = pc[2];
  endtask

  task automatic randomE();
    E_Valid     = ($urandom_range(0, 4) != 0);
    E_PC        = $urandom;
    E_Instr     = $urandom;
    E_ALURes    = $urandom;
    E_WriteData = $urandom;
    E_WriteReg  = 5'($urandom);
    E_BD        = 1'($urandom);
    E_ExcCode   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
    E_Ari_Ov    = ($urandom_range(0, 3) == 0);
    E_DM_Ov     = ($urandom_range(0, 2) == 0);
    E_IsLoad    = 1'($urandom);
    E_IsStore   = E_IsLoad ? 1'b0 : 1'($urandom);
  endtask

  initial begin
    model = zeroState();

    applyStimulus(1, 0, 0);
    checkOutput("rst_pc", M_PC, 32'h0);

    // Plain load
    setE(1, 32'h0000_3000, 32'h1234, 5'd8, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("ld_pc", M_PC, 32'h0000_3000);
    checkOutput("ld_alu", M_ALURes, 32'h1234);
    checkOutput("ld_wr", {27'd0, M_WriteReg}, 32'd8);
    checkOutput("ld_exc", {27'd0, M_ExcCode}, 32'd0);

    // Arithmetic overflow
    setE(1, 32'h0000_3004, 32'h8000_0000, 5'd9, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("ov_exc", {27'd0, M_ExcCode}, 32'd12);
    checkOutput("ov_wr", {27'd0, M_WriteReg}, 32'd0);
    checkOutput("ov_alu", M_ALURes, 32'h8000_0000);

    // Address errors on store then load
    setE(1, 32'h0000_3008, 32'h0000_0003, 5'd0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("ades_exc", {27'd0, M_ExcCode}, 32'd5);
    checkOutput("ades_st", {31'd0, M_IsStore}, 32'd0);
    setE(1, 32'h0000_300C, 32'h0000_0001, 5'd4, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("adel_exc", {27'd0, M_ExcCode}, 32'd4);
    checkOutput("adel_ld", {31'd0, M_IsLoad}, 32'd0);

    // Earlier exception beats overflow
    setE(1, 32'h0000_3010, 32'h7FFF_FFFF, 5'd3, 5'd10, 1, 0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("ri_exc", {27'd0, M_ExcCode}, 32'd10);

    // Stall holds, then stall+flush clears
    setE(1, 32'h0000_3004, 32'h55, 5'd2, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      randomE();
      applyStimulus(0, 1, 0);
      checkOutput("stall_pc", M_PC, 32'h0000_3004);
      checkOutput("stall_wr", {27'd0, M_WriteReg}, 32'd2);
    end
    applyStimulus(0, 1, 1);
    checkOutput("flush_pc", M_PC, 32'h0);
    checkOutput("flush_valid", {31'd0, M_Valid}, 32'd0);

    // Reset during stall, then normal load
    setE(1, 32'h0000_4000, 32'hCAFE, 5'd17, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("rststall_pc", M_PC, 32'h0);
    checkOutput("rststall_st", {31'd0, M_IsStore}, 32'd0);
    setE(1, 32'h0000_4004, 32'hBEEF, 5'd18, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("postrst_pc", M_PC, 32'h0000_4004);
    checkOutput("postrst_wr", {27'd0, M_WriteReg}, 32'd18);

    // Invalid slot with overflow flags carries no control
    setE(0, 32'h0000_5000, 32'h1, 5'd7, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("inv_exc", {27'd0, M_ExcCode}, 32'd0);
    checkOutput("inv_pc", M_PC, 32'h0000_5000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomE();
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
